// File: rtl/mem_pkg.sv
// Shared types and helpers for the simple-dual-port memory with clear engine.
package mem_pkg;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_e;

  // Widest word the merge helper handles; callers zero-extend and truncate.
  localparam int unsigned MERGE_MAX_W = 1024;

  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0] old_word,
    input logic [MERGE_MAX_W-1:0] new_word,
    input logic [MERGE_MAX_W-1:0] be,
    input int unsigned            byte_width
  );
    logic [MERGE_MAX_W-1:0] merged;
    merged = old_word;
    for (int unsigned b = 0; b < MERGE_MAX_W; b++) begin
      if (be[b / byte_width]) merged[b] = new_word[b];
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_clear_fsm.sv
// Clear engine: owns the write port while zero-filling, passes user writes otherwise.
module mem_clear_fsm
  import mem_pkg::*;
#(
  parameter int unsigned              ADDR_WIDTH  = 10,
  parameter int unsigned              DATA_WIDTH  = 32,
  parameter int unsigned              NB          = 4,
  parameter int unsigned              RAM_DEPTH   = 1 << ADDR_WIDTH,
  parameter logic [DATA_WIDTH-1:0]    CLEAR_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_req,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [NB-1:0]         wr_be,
  output logic                  busy,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [NB-1:0]         mem_be
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

  clr_state_e            state, state_nx;
  logic [ADDR_WIDTH-1:0] clr_addr, clr_addr_nx;
  logic                  wr_in_range;

  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= CLR_RUN;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_addr_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    clr_addr_nx = clr_addr;
    busy        = (state == CLR_RUN);
    mem_we      = 1'b0;
    mem_addr    = wr_addr;
    mem_data    = wr_data;
    mem_be      = wr_be;
    case (state)
      CLR_RUN: begin
        mem_we   = 1'b1;
        mem_addr = clr_addr;
        mem_data = CLEAR_VALUE;
        mem_be   = '1;
        if (clr_addr == LAST_ADDR) begin
          state_nx    = CLR_IDLE;
          clr_addr_nx = '0;
        end else begin
          clr_addr_nx = clr_addr + 1'b1;
        end
      end
      default: begin
        mem_we = wr_en && wr_in_range;
        if (clear_req) begin
          state_nx    = CLR_RUN;
          clr_addr_nx = '0;
        end
      end
    endcase
  end

endmodule

// File: rtl/sdp_memory_clr.sv
// Simple-dual-port RAM with byte enables, read-during-write mode, optional
// output register and a hardware clear engine.
module sdp_memory_clr
  import mem_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           ADDR_WIDTH  = 10,
  parameter int unsigned           RAM_DEPTH   = 1 << ADDR_WIDTH,
  parameter int unsigned           BYTE_WIDTH  = 8,
  parameter int unsigned           RDW_MODE    = 0,
  parameter int unsigned           OUT_REG     = 0,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clear_req,
  output logic                             busy,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wr_be,
  input  logic                             rd_en,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             rd_valid
);

  localparam int unsigned         NB        = DATA_WIDTH / BYTE_WIDTH;
  localparam rdw_mode_e           RDW       = (RDW_MODE != 0) ? RDW_WRITE_FIRST : RDW_READ_FIRST;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(RAM_DEPTH);

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [NB-1:0]         mem_be;

  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

  logic                  rd_accept;
  logic                  rd_in_range;
  logic                  rd_fwd;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_data;

  mem_clear_fsm #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .NB          (NB),
    .RAM_DEPTH   (RAM_DEPTH),
    .CLEAR_VALUE (CLEAR_VALUE)
  ) u_clear_fsm (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_be    (mem_be)
  );

  // Array has no reset; it is initialised only through the clear engine.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= mem_data[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  assign rd_accept   = rd_en && !busy;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
  // mem_we outside busy is exactly an accepted in-range user write.
  assign rd_fwd      = (RDW == RDW_WRITE_FIRST) && mem_we && !busy && (wr_addr == rd_addr);

  always_comb begin
    rd_word = CLEAR_VALUE;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
      if (rd_fwd) begin
        rd_word = DATA_WIDTH'(byte_merge(MERGE_MAX_W'(mem[rd_addr]), MERGE_MAX_W'(wr_data),
                                         MERGE_MAX_W'(wr_be), BYTE_WIDTH));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_accept;
      if (rd_accept) s1_data <= rd_word;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  s2_valid;
      logic [DATA_WIDTH-1:0] s2_data;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end

      assign rd_valid = s2_valid;
      assign rd_data  = s2_data;
    end else begin : g_no_out_reg
      assign rd_valid = s1_valid;
      assign rd_data  = s1_data;
    end
  endgenerate

endmodule
